// File: rtl/core_port_pkg.sv
// Shared constants and types for the adder core input/output port wrappers.
package core_port_pkg;

    localparam int DATA_W     = 32;
    localparam int NUM_PORTS  = 4;
    localparam int ADDR_W     = $clog2(NUM_PORTS);
    localparam int FIFO_DEPTH = 4;
    localparam int STAT_W     = 16;

    typedef logic [DATA_W-1:0] port_word_t;
    typedef logic [ADDR_W-1:0] port_addr_t;

    function automatic logic [NUM_PORTS-1:0] port_onehot(input port_addr_t addr);
        logic [NUM_PORTS-1:0] vec;
        vec = '0;
        vec[addr] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/port_fifo.sv
// Single-clock FIFO of DEPTH words (power of two); push is ignored when full, pop when empty.
module port_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = empty ? '0 : mem[rd_ptr];

    // Storage is not reset; an empty FIFO masks stale contents at the head.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/core_in_ports.sv
// Input port bank feeding the adder core: per-port FIFOs, head mux, falling-edge pop, rd_err.
// Optional per-port pop statistics when IN_PORT_STATS_EN is defined.
module core_in_ports
    import core_port_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_PORTS-1:0]        net_valid,
    input  logic [NUM_PORTS*DATA_W-1:0] net_data,
    output logic [NUM_PORTS-1:0]        net_ready,
    input  port_addr_t                  in_addr,
    input  logic                        read,
    output logic [NUM_PORTS-1:0]        in_ready,
    output port_word_t                  data_in,
    output logic                        rd_err
`ifdef IN_PORT_STATS_EN
    ,
    input  port_addr_t                  stat_sel,
    output logic [STAT_W-1:0]           stat_count
`endif
);

    // Handshakes: a network word transfers on a clock where net_valid[p] and net_ready[p]
    // are both high, and the sender holds it otherwise. read is a level strobe; the word
    // on data_in is consumed on the clock where read falls, at the in_addr of that clock.

    port_word_t           head [NUM_PORTS];
    logic [NUM_PORTS-1:0] full;
    logic [NUM_PORTS-1:0] empty;
    logic [NUM_PORTS-1:0] pop_vec;
    logic                 read_q;
    logic                 pop_evt;

    assign pop_evt   = read_q && !read;
    assign pop_vec   = pop_evt ? port_onehot(in_addr) : '0;
    assign data_in   = head[in_addr];
    assign in_ready  = ~empty;
    assign net_ready = ~full;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        port_fifo #(
            .W     (DATA_W),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clock (clock),
            .reset (reset),
            .push  (net_valid[p]),
            .pop   (pop_vec[p]),
            .wdata (net_data[p*DATA_W +: DATA_W]),
            .head  (head[p]),
            .full  (full[p]),
            .empty (empty[p])
        );
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            read_q <= 1'b0;
            rd_err <= 1'b0;
        end else begin
            read_q <= read;
            if (pop_evt && empty[in_addr]) begin
                rd_err <= 1'b1;
            end
        end
    end

`ifdef IN_PORT_STATS_EN
    logic [STAT_W-1:0] pop_cnt [NUM_PORTS];

    assign stat_count = pop_cnt[stat_sel];

    // Counts only pops that removed a word, saturating at all ones.
    always_ff @(posedge clock) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (reset) begin
                pop_cnt[p] <= '0;
            end else if (pop_vec[p] && !empty[p] && (pop_cnt[p] != '1)) begin
                pop_cnt[p] <= pop_cnt[p] + STAT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_core_in_ports.sv
// Self-checking bench for core_in_ports: reset, table-driven push/pop, full/concurrent
// corners, empty-pop error and reset mid-read. Stats checks apply when IN_PORT_STATS_EN is defined.
module tb_core_in_ports;

    localparam int W  = 32;
    localparam int NP = 4;
    localparam int D  = 4;

    logic            clock = 1'b0;
    logic            reset;
    logic [NP-1:0]   net_valid;
    logic [NP*W-1:0] net_data;
    logic [NP-1:0]   net_ready;
    logic [1:0]      in_addr;
    logic            read;
    logic [NP-1:0]   in_ready;
    logic [W-1:0]    data_in;
    logic            rd_err;
`ifdef IN_PORT_STATS_EN
    logic [1:0]      stat_sel;
    logic [15:0]     stat_count;
`endif

    core_in_ports dut (
        .clock     (clock),
        .reset     (reset),
        .net_valid (net_valid),
        .net_data  (net_data),
        .net_ready (net_ready),
        .in_addr   (in_addr),
        .read      (read),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .rd_err    (rd_err)
`ifdef IN_PORT_STATS_EN
        ,
        .stat_sel  (stat_sel),
        .stat_count(stat_count)
`endif
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Scoreboard: words expected out of each port, and successful pops per port.
    logic [W-1:0] exp_q [NP][$];
    int           pops_m [NP];

    typedef struct {
        bit           is_pop;
        int           port;
        logic [W-1:0] data;
        logic [3:0]   exp_ir;
        logic [3:0]   exp_nr;
    } vec_t;

    vec_t vecs [13];

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] head_m(input int p);
        return (exp_q[p].size() > 0) ? exp_q[p][0] : '0;
    endfunction

    function automatic logic [NP-1:0] model_ir();
        logic [NP-1:0] v;
        for (int p = 0; p < NP; p++) v[p] = (exp_q[p].size() != 0);
        return v;
    endfunction

    function automatic logic [NP-1:0] model_nr();
        logic [NP-1:0] v;
        for (int p = 0; p < NP; p++) v[p] = (exp_q[p].size() < D);
        return v;
    endfunction

    task automatic model_pop(input int p);
        if (exp_q[p].size() > 0) begin
            void'(exp_q[p].pop_front());
            pops_m[p]++;
        end
    endtask

    task automatic push_word(input int p, input logic [W-1:0] d);
        net_valid[p] = 1'b1;
        net_data[p*W +: W] = d;
        tick();
        net_valid[p] = 1'b0;
        if (exp_q[p].size() < D) exp_q[p].push_back(d);
    endtask

    task automatic pop_word(input int p, input int hold, input string name);
        in_addr = 2'(p);
        read = 1'b1;
        repeat (hold) begin
            tick();
            chk({name, " data_in hold"}, data_in, head_m(p));
        end
        read = 1'b0;
        chk({name, " data_in fall"}, data_in, head_m(p));
        tick();
        model_pop(p);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{0, 2, 32'hA000_0000, 4'b0100, 4'b1111};
        vecs[1]  = '{0, 2, 32'hA000_0001, 4'b0100, 4'b1111};
        vecs[2]  = '{0, 0, 32'hC000_0000, 4'b0101, 4'b1111};
        vecs[3]  = '{0, 2, 32'hA000_0002, 4'b0101, 4'b1111};
        vecs[4]  = '{0, 2, 32'hA000_0003, 4'b0101, 4'b1011};
        vecs[5]  = '{0, 2, 32'hA000_0004, 4'b0101, 4'b1011};
        vecs[6]  = '{1, 2, 32'h0,         4'b0101, 4'b1111};
        vecs[7]  = '{0, 2, 32'hA000_0004, 4'b0101, 4'b1011};
        vecs[8]  = '{1, 0, 32'h0,         4'b0100, 4'b1011};
        vecs[9]  = '{1, 2, 32'h0,         4'b0100, 4'b1111};
        vecs[10] = '{1, 2, 32'h0,         4'b0100, 4'b1111};
        vecs[11] = '{1, 2, 32'h0,         4'b0100, 4'b1111};
        vecs[12] = '{1, 2, 32'h0,         4'b0000, 4'b1111};

        for (int p = 0; p < NP; p++) pops_m[p] = 0;
        reset     = 1'b1;
        net_valid = 4'hF;
        net_data  = '0;
        for (int p = 0; p < NP; p++) net_data[p*W +: W] = $urandom;
        in_addr   = 2'd0;
        read      = 1'b0;
`ifdef IN_PORT_STATS_EN
        stat_sel  = 2'd0;
`endif

        // Reset with writes requested on every port
        tick();
        chk("reset in_ready", 32'(in_ready), 32'h0);
        chk("reset net_ready", 32'(net_ready), 32'hF);
        chk("reset rd_err", 32'(rd_err), 32'h0);
        chk("reset data_in", data_in, 32'h0);
        reset     = 1'b0;
        net_valid = '0;
        tick();
        chk("post reset in_ready", 32'(in_ready), 32'h0);

        // Single word, long read strobe: one pop on the falling edge only
        push_word(1, 32'h1111_1111);
        chk("p1 in_ready", 32'(in_ready), 32'h2);
        pop_word(1, 3, "p1 read");
        chk("p1 single pop in_ready", 32'(in_ready), 32'h0);
        chk("p1 single pop rd_err", 32'(rd_err), 32'h0);

        // Table: fill port 2 past full, wrap read pointer, interleave port 0
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].is_pop) pop_word(vecs[i].port, 1, $sformatf("vec%0d pop", i));
            else push_word(vecs[i].port, vecs[i].data);
            chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vecs[i].exp_ir));
            chk($sformatf("vec%0d net_ready", i), 32'(net_ready), 32'(vecs[i].exp_nr));
            chk($sformatf("vec%0d rd_err", i), 32'(rd_err), 32'h0);
        end

        // Port 0 full: pop and push in the same cycle, push must wait one cycle
        for (int k = 0; k < D; k++) push_word(0, 32'hB000_0000 + 32'(k));
        chk("p0 full net_ready", 32'(net_ready[0]), 32'h0);
        in_addr = 2'd0;
        read = 1'b1;
        tick();
        read = 1'b0;
        net_valid[0] = 1'b1;
        net_data[0 +: W] = 32'hB000_0004;
        chk("p0 full pop data", data_in, head_m(0));
        tick();
        model_pop(0);
        chk("p0 pop taken net_ready", 32'(net_ready[0]), 32'h1);
        chk("p0 pop taken in_ready", 32'(in_ready), 32'(model_ir()));
        tick();
        net_valid[0] = 1'b0;
        exp_q[0].push_back(32'hB000_0004);
        chk("p0 delayed push net_ready", 32'(net_ready[0]), 32'h0);
        pop_word(0, 1, "p0 drain a");
        pop_word(0, 1, "p0 drain b");

        // Port 0 holding two words: push and pop together keep the count
        read = 1'b1;
        tick();
        read = 1'b0;
        net_valid[0] = 1'b1;
        net_data[0 +: W] = 32'hB000_0005;
        chk("p0 concurrent pop data", data_in, head_m(0));
        tick();
        net_valid[0] = 1'b0;
        model_pop(0);
        exp_q[0].push_back(32'hB000_0005);
        chk("p0 concurrent net_ready", 32'(net_ready), 32'(model_nr()));
        chk("p0 concurrent in_ready", 32'(in_ready), 32'(model_ir()));
        pop_word(0, 2, "p0 tail a");
        chk("p0 count kept in_ready", 32'(in_ready[0]), 32'h1);
        pop_word(0, 1, "p0 tail b");
        chk("p0 drained in_ready", 32'(in_ready[0]), 32'h0);

        // Empty-port pop sets the sticky error without disturbing other ports
        push_word(2, $urandom);
        pop_word(3, 1, "p3 empty");
        chk("p3 empty rd_err", 32'(rd_err), 32'h1);
        chk("p3 empty in_ready", 32'(in_ready), 32'(model_ir()));
        chk("p3 empty net_ready", 32'(net_ready), 32'(model_nr()));
        repeat ($urandom_range(2, 5)) tick();
        chk("rd_err sticky", 32'(rd_err), 32'h1);
        in_addr = 2'd2;
        #1;
        chk("p2 unaffected data", data_in, head_m(2));

`ifdef IN_PORT_STATS_EN
        for (int p = 0; p < NP; p++) begin
            stat_sel = 2'(p);
            #1;
            chk($sformatf("stat port%0d", p), 32'(stat_count), 32'(pops_m[p]));
        end
`endif

        // Reset during a read with two ports partly full
        push_word(1, $urandom);
        push_word(1, $urandom);
        in_addr = 2'd1;
        read = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        for (int p = 0; p < NP; p++) exp_q[p].delete();
        chk("mid reset in_ready", 32'(in_ready), 32'h0);
        chk("mid reset net_ready", 32'(net_ready), 32'hF);
        chk("mid reset data_in", data_in, 32'h0);
        chk("mid reset rd_err", 32'(rd_err), 32'h0);
        reset = 1'b0;
        read = 1'b0;
        tick();
        chk("after reset no pop rd_err", 32'(rd_err), 32'h0);
        chk("after reset in_ready", 32'(in_ready), 32'h0);
`ifdef IN_PORT_STATS_EN
        for (int p = 0; p < NP; p++) begin
            stat_sel = 2'(p);
            #1;
            chk($sformatf("stat reset port%0d", p), 32'(stat_count), 32'h0);
        end
`endif

        // Bank still works after reset
        push_word(3, 32'h3333_3333);
        pop_word(3, 1, "p3 after reset");
        chk("p3 after reset rd_err", 32'(rd_err), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
